eoc_tohost_reporter: RTL and testbench

EOC_TOHOST_REPORTER -- requirements
Module: eoc_tohost_reporter

---
 rtl/eoc_pkg.sv | 25 ++
 rtl/eoc_tohost_reporter_if.sv | 26 ++
 rtl/eoc_cycle_counter.sv | 39 +++
 rtl/eoc_tohost_reporter.sv | 152 +++++++++++++++
 tb/tb_eoc_tohost_reporter.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/eoc_pkg.sv
// Shared definitions for the end-of-computation / runtime reporter.
// Holds the register map (byte offsets) and the control FSM state type.
// Address decode ignores the byte-lane bits [2:0] of the 5-bit offset.
package eoc_pkg;

  localparam logic [4:0] OFS_TOHOST   = 5'h00;
  localparam logic [4:0] OFS_RT_START = 5'h08;
  localparam logic [4:0] OFS_RT_STOP  = 5'h10;
  localparam logic [4:0] OFS_RUNTIME  = 5'h18;

  // Only the 64-bit word index takes part in decode.
  localparam logic [4:0] WORD_MASK    = 5'b11000;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_COUNTING = 2'd1,
    ST_EXITED   = 2'd2
  } state_e;

  // True when a byte offset falls into the word of the given register.
  function automatic logic reg_hit(input logic [4:0] addr, input logic [4:0] ofs);
    return (addr & WORD_MASK) == ofs;
  endfunction

endpackage

// File: rtl/eoc_tohost_reporter_if.sv
// Core-side register access bus of the reporter.
// Latency: response (rvalid_o/rdata_o) one cycle after a granted request.
// Backpressure: none, the slave grants every request in the same cycle.
interface eoc_tohost_reporter_if #(
  parameter int DataWidth = 64
);

  logic                 req_i;
  logic                 we_i;
  logic [4:0]           addr_i;
  logic [DataWidth-1:0] wdata_i;
  logic                 gnt_o;
  logic                 rvalid_o;
  logic [DataWidth-1:0] rdata_o;

  modport master (
    output req_i, we_i, addr_i, wdata_i,
    input  gnt_o, rvalid_o, rdata_o
  );

  modport slave (
    input  req_i, we_i, addr_i, wdata_i,
    output gnt_o, rvalid_o, rdata_o
  );

endinterface

// File: rtl/eoc_cycle_counter.sv
// Saturating cycle counter with synchronous clear and count enable.
// Latency: clear and increment take effect on the next rising edge.
// Backpressure: none; sticks at all-ones instead of wrapping.
module eoc_cycle_counter #(
  parameter int Width = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [Width-1:0] cnt_o
);

  logic [Width-1:0] cnt_q;
  logic [Width-1:0] base;

  // A clear restarts from zero and the clearing cycle itself is counted when
  // enabled, so the value k cycles after the clear equals k.
  always_comb begin
    base = cnt_q;
    if (clr_i) begin
      base = '0;
    end
  end

  // Count register: increments while enabled, holds at all-ones.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (en_i && !(&base)) begin
      cnt_q <= base + Width'(1);
    end else begin
      cnt_q <= base;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/eoc_tohost_reporter.sv
// tohost end-of-computation register plus a start/stop runtime measurement.
// Latency: grant combinational, response one cycle later; exit_o/runtime_o
// update on the edge that ends the granted write. Backpressure: none.
module eoc_tohost_reporter
  import eoc_pkg::*;
#(
  parameter int DataWidth = 64,
  parameter int CntWidth  = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  eoc_tohost_reporter_if.slave  bus,
  output logic [DataWidth-1:0]  exit_o,
  output logic [CntWidth-1:0]   runtime_o
);

  state_e               state_q, state_d;
  logic [DataWidth-1:0] exit_q;
  logic [DataWidth-1:0] shadow_q;
  logic [CntWidth-1:0]  runtime_q;
  logic                 rvalid_q;
  logic [DataWidth-1:0] rdata_q;
  logic [DataWidth-1:0] rd_sel;
  logic [CntWidth-1:0]  cnt;

  logic wr_acc, rd_acc;
  logic wr_tohost, wr_start, wr_stop;
  logic cnt_clr, cnt_en, rt_load, exit_load, shadow_load;

  assign wr_acc    = bus.req_i &  bus.we_i;
  assign rd_acc    = bus.req_i & ~bus.we_i;
  assign wr_tohost = wr_acc & reg_hit(bus.addr_i, OFS_TOHOST);
  assign wr_start  = wr_acc & reg_hit(bus.addr_i, OFS_RT_START);
  assign wr_stop   = wr_acc & reg_hit(bus.addr_i, OFS_RT_STOP);

  eoc_cycle_counter #(
    .Width (CntWidth)
  ) u_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (cnt_clr),
    .en_i  (cnt_en),
    .cnt_o (cnt)
  );

  // FSM state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and per-cycle control strobes; the exiting TOHOST write wins
  // over every other action, and EXITED ignores all writes.
  always_comb begin
    state_d     = state_q;
    cnt_clr     = 1'b0;
    cnt_en      = 1'b0;
    rt_load     = 1'b0;
    exit_load   = 1'b0;
    shadow_load = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (wr_tohost) begin
          shadow_load = 1'b1;
          if (bus.wdata_i[0]) begin
            exit_load = 1'b1;
            state_d   = ST_EXITED;
          end
        end else if (wr_start) begin
          cnt_clr = 1'b1;
          cnt_en  = 1'b1;
          state_d = ST_COUNTING;
        end
      end
      ST_COUNTING: begin
        cnt_en = 1'b1;
        if (wr_tohost) begin
          shadow_load = 1'b1;
          if (bus.wdata_i[0]) begin
            exit_load = 1'b1;
            rt_load   = 1'b1;
            cnt_en    = 1'b0;
            state_d   = ST_EXITED;
          end
        end else if (wr_start) begin
          cnt_clr = 1'b1;
        end else if (wr_stop) begin
          rt_load = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_EXITED: begin
        state_d = ST_EXITED;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Exit word, TOHOST shadow and runtime buffer; the count sampled is the
  // value before this cycle's increment, i.e. stop cycle minus start cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      exit_q    <= '0;
      shadow_q  <= '0;
      runtime_q <= '0;
    end else begin
      if (exit_load) begin
        exit_q <= bus.wdata_i;
      end
      if (shadow_load) begin
        shadow_q <= bus.wdata_i;
      end
      if (rt_load) begin
        runtime_q <= cnt;
      end
    end
  end

  // Read mux over current register contents; unmapped words read as zero.
  always_comb begin
    rd_sel = '0;
    if (reg_hit(bus.addr_i, OFS_TOHOST)) begin
      rd_sel = shadow_q;
    end else if (reg_hit(bus.addr_i, OFS_RUNTIME)) begin
      rd_sel = DataWidth'(runtime_q);
    end
  end

  // Registered response: one cycle after every granted access, zero data
  // for writes.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= bus.req_i;
      rdata_q  <= rd_acc ? rd_sel : '0;
    end
  end

  assign bus.gnt_o    = bus.req_i;
  assign bus.rvalid_o = rvalid_q;
  assign bus.rdata_o  = rdata_q;
  assign exit_o       = exit_q;
  assign runtime_o    = runtime_q;

endmodule

// File: tb/tb_eoc_tohost_reporter.sv
// Directed bench for eoc_tohost_reporter: a 64-bit counter instance and a
// 4-bit counter instance receive identical stimulus and are checked against
// hand-computed values.
module tb_eoc_tohost_reporter;
  import eoc_pkg::*;

  logic clk_i;
  logic rst_i;

  eoc_tohost_reporter_if #(.DataWidth(64)) bus ();
  eoc_tohost_reporter_if #(.DataWidth(64)) bus4 ();

  assign bus4.req_i   = bus.req_i;
  assign bus4.we_i    = bus.we_i;
  assign bus4.addr_i  = bus.addr_i;
  assign bus4.wdata_i = bus.wdata_i;

  logic [63:0] exit64, exit4;
  logic [63:0] rt64;
  logic [3:0]  rt4;

  eoc_tohost_reporter #(.DataWidth(64), .CntWidth(64)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .bus       (bus),
    .exit_o    (exit64),
    .runtime_o (rt64)
  );

  eoc_tohost_reporter #(.DataWidth(64), .CntWidth(4)) dut4 (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .bus       (bus4),
    .exit_o    (exit4),
    .runtime_o (rt4)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One granted access in the current cycle; returns 1 ns after its edge.
  task automatic access(input logic we, input logic [4:0] a, input logic [63:0] d);
    bus.req_i   = 1'b1;
    bus.we_i    = we;
    bus.addr_i  = a;
    bus.wdata_i = d;
    @(posedge clk_i);
    #1;
    bus.req_i   = 1'b0;
    bus.we_i    = 1'b0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [63:0] d);
    access(1'b1, a, d);
  endtask

  task automatic rd(input string tag, input logic [4:0] a,
                    input logic [63:0] exp64, input logic [63:0] exp4);
    access(1'b0, a, 64'd0);
    chk({tag, "_vld"}, {63'd0, bus.rvalid_o}, 64'd1);
    chk(tag, bus.rdata_o, exp64);
    chk({tag, "_c4"}, bus4.rdata_o, exp4);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic chk_rt(input string tag, input logic [63:0] e64, input logic [63:0] e4);
    chk(tag, rt64, e64);
    chk({tag, "_c4"}, {60'd0, rt4}, e4);
  endtask

  initial begin
    int errs;
    bus.req_i   = 1'b0;
    bus.we_i    = 1'b0;
    bus.addr_i  = '0;
    bus.wdata_i = '0;
    rst_i = 1'b0;
    #1 rst_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;

    // Reset state
    chk("rst_exit", exit64, 64'd0);
    chk("rst_runtime", rt64, 64'd0);
    chk("rst_rvalid", {63'd0, bus.rvalid_o}, 64'd0);
    chk("rst_rdata", bus.rdata_o, 64'd0);

    // 100 quiet cycles
    errs = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk_i);
      #1;
      if (exit64 != 0 || rt64 != 0 || bus.rvalid_o != 1'b0) errs++;
    end
    chk("quiet_100", errs, 0);

    // Combinational grant, unmapped read returns 0
    bus.req_i  = 1'b1;
    bus.we_i   = 1'b0;
    bus.addr_i = OFS_RT_START;
    #1;
    chk("gnt_comb", {63'd0, bus.gnt_o}, 64'd1);
    @(posedge clk_i);
    #1;
    bus.req_i = 1'b0;
    chk("rd_unmapped_vld", {63'd0, bus.rvalid_o}, 64'd1);
    chk("rd_unmapped", bus.rdata_o, 64'd0);

    // Start / stop 100 cycles apart
    wr(OFS_RT_START, 64'd0);
    idle(99);
    wr(OFS_RT_STOP, 64'd0);
    chk_rt("rt_100", 64'd100, 64'd15);
    chk("wr_ack_vld", {63'd0, bus.rvalid_o}, 64'd1);
    chk("wr_ack_data", bus.rdata_o, 64'd0);
    rd("rd_runtime", OFS_RUNTIME, 64'd100, 64'd15);
    rd("rd_runtime_lowbits", 5'h1C, 64'd100, 64'd15);

    // Stop in IDLE has no effect
    wr(OFS_RT_STOP, 64'd0);
    chk_rt("stop_in_idle", 64'd100, 64'd15);

    // Restart mid-count
    wr(OFS_RT_START, 64'd0);
    idle(20);
    wr(OFS_RT_START, 64'd0);
    idle(29);
    wr(OFS_RT_STOP, 64'd0);
    chk_rt("rt_restart", 64'd30, 64'd15);

    // Short interval, no saturation in either width
    wr(OFS_RT_START, 64'd0);
    idle(9);
    wr(OFS_RT_STOP, 64'd0);
    chk_rt("rt_10", 64'd10, 64'd10);

    // 40-cycle interval saturates the 4-bit counter
    wr(OFS_RT_START, 64'd0);
    idle(39);
    wr(OFS_RT_STOP, 64'd0);
    chk_rt("rt_40", 64'd40, 64'd15);

    // TOHOST with bit0 clear only updates the shadow
    wr(OFS_TOHOST, 64'h1234_5678_0000_0AB6);
    chk("shadow_no_exit", exit64, 64'd0);
    rd("rd_shadow", OFS_TOHOST, 64'h1234_5678_0000_0AB6, 64'h1234_5678_0000_0AB6);

    // Exit while counting: runtime latched, code 10
    wr(OFS_RT_START, 64'd0);
    idle(49);
    wr(OFS_TOHOST, 64'h15);
    chk("exit_0x15", exit64, 64'h15);
    chk("exit_code", exit64 >> 1, 64'd10);
    chk("exit_0x15_c4", exit4, 64'h15);
    chk_rt("rt_exit_50", 64'd50, 64'd15);

    // EXITED is frozen; writes still acknowledged
    wr(OFS_RT_START, 64'd0);
    idle(10);
    wr(OFS_RT_STOP, 64'd0);
    chk_rt("rt_frozen", 64'd50, 64'd15);
    wr(OFS_TOHOST, 64'h7);
    chk("exited_wr_ack", {63'd0, bus.rvalid_o}, 64'd1);
    chk("exit_frozen", exit64, 64'h15);
    rd("rd_shadow_exited", OFS_TOHOST, 64'h15, 64'h15);

    // Async reset in EXITED with a read outstanding
    bus.req_i  = 1'b1;
    bus.we_i   = 1'b0;
    bus.addr_i = OFS_TOHOST;
    #2 rst_i = 1'b1;
    #1;
    chk("arst_exit", exit64, 64'd0);
    chk("arst_runtime", rt64, 64'd0);
    chk("arst_rvalid", {63'd0, bus.rvalid_o}, 64'd0);
    chk("arst_rdata", bus.rdata_o, 64'd0);
    bus.req_i = 1'b0;
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(posedge clk_i);
    #1;
    chk("no_resp_after_rst", {63'd0, bus.rvalid_o}, 64'd0);
    rd("rd_shadow_rst", OFS_TOHOST, 64'd0, 64'd0);

    // Exit without counting, then later write ignored
    wr(OFS_TOHOST, 64'h1);
    chk("exit_0x1", exit64, 64'h1);
    wr(OFS_TOHOST, 64'h7);
    chk("exit_stays_0x1", exit64, 64'h1);

    // Reset from EXITED, measure, then reset mid-count
    #3 rst_i = 1'b1;
    #1;
    chk("arst_exit2", exit64, 64'd0);
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    wr(OFS_RT_START, 64'd0);
    idle(4);
    wr(OFS_RT_STOP, 64'd0);
    chk_rt("rt_5", 64'd5, 64'd5);
    wr(OFS_RT_START, 64'd0);
    idle(20);
    #3 rst_i = 1'b1;
    #1;
    chk_rt("arst_midcount", 64'd0, 64'd0);
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    wr(OFS_RT_STOP, 64'd0);
    chk_rt("stop_after_rst", 64'd0, 64'd0);
    wr(OFS_RT_START, 64'd0);
    idle(24);
    wr(OFS_RT_STOP, 64'd0);
    chk_rt("rt_fresh_25", 64'd25, 64'd15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
